// File: rtl/spi_ip_flag_bank.sv
// -----------------------------------------------------------------------------
// spi_ip_flag_bank
//
// Purpose:
//   A bank of PARAM_CHANNELS asynchronous flag inputs. Each flag is brought
//   into the fb_clk_i domain through its own synchronizer chain. An event is
//   then detected per channel according to a programmable mode (level, rising,
//   falling or both edges). Events set a sticky status bit. An event that
//   arrives while the status bit is still set raises a sticky overflow bit.
//   A registered interrupt is formed from the status bits that are enabled in
//   the mask. A saturating counter totals all events, and the mask does not
//   affect that count.
//
// Ports:
//   fb_clk_i         in   1     single clock, all state on its rising edge
//   fb_rst_i         in   1     synchronous active-high reset
//   fb_flag_async_i  in   N     asynchronous flag inputs
//   fb_mode_i        in   2N    per-channel mode [2k+1:2k]:
//                               00 level-high, 01 rising, 10 falling, 11 both
//   fb_mask_i        in   N     per-channel interrupt enable
//   fb_clear_i       in   N     write-1-to-clear for status and overflow
//   fb_cnt_clr_i     in   1     event-counter clear strobe
//   fb_flag_sync_o   out  N     synchronized flag levels (last sync stage)
//   fb_status_o      out  N     sticky event status
//   fb_overflow_o    out  N     sticky "event lost" indication
//   fb_irq_o         out  1     registered interrupt request
//   fb_event_cnt_o   out  W     saturating total event count
//
// There is no handshake on this block. Every strobe input acts on the clock
// edge where it is high.
// -----------------------------------------------------------------------------
module spi_ip_flag_bank #(
  parameter int PARAM_CHANNELS    = 4,
  parameter int PARAM_SYNC_STAGES = 2,
  parameter int PARAM_FLAG_RESET  = 0,
  parameter int PARAM_CNT_WIDTH   = 4
) (
  input  logic                          fb_clk_i,
  input  logic                          fb_rst_i,
  input  logic [PARAM_CHANNELS-1:0]     fb_flag_async_i,
  input  logic [2*PARAM_CHANNELS-1:0]   fb_mode_i,
  input  logic [PARAM_CHANNELS-1:0]     fb_mask_i,
  input  logic [PARAM_CHANNELS-1:0]     fb_clear_i,
  input  logic                          fb_cnt_clr_i,
  output logic [PARAM_CHANNELS-1:0]     fb_flag_sync_o,
  output logic [PARAM_CHANNELS-1:0]     fb_status_o,
  output logic [PARAM_CHANNELS-1:0]     fb_overflow_o,
  output logic                          fb_irq_o,
  output logic [PARAM_CNT_WIDTH-1:0]    fb_event_cnt_o
);

  localparam int N     = PARAM_CHANNELS;
  localparam int S     = PARAM_SYNC_STAGES;
  localparam int W     = PARAM_CNT_WIDTH;
  localparam int POP_W = $clog2(N + 1);
  // The sum is one bit wider than either operand, so it cannot wrap before
  // the saturation compare.
  localparam int SUM_W = ((W > POP_W) ? W : POP_W) + 1;

  localparam logic [N-1:0]     FLAG_RST_VEC = {N{(PARAM_FLAG_RESET != 0)}};
  localparam logic [SUM_W-1:0] CNT_MAX      = {{(SUM_W - W){1'b0}}, {W{1'b1}}};

  // Detect modes
  localparam logic [1:0] MODE_LEVEL   = 2'b00;
  localparam logic [1:0] MODE_RISING  = 2'b01;
  localparam logic [1:0] MODE_FALLING = 2'b10;

  // ---------------------------------------------------------------------------
  // Synchronizer chain and edge history
  // ---------------------------------------------------------------------------
  logic [N-1:0] sync_q [S];
  logic [N-1:0] prev_q;
  logic [N-1:0] flag_sync;

  assign flag_sync = sync_q[S-1];

  // prev_q resets to the same value as the sync stages. As a result, an input
  // that holds the reset level through reset release does not look like an
  // edge.
  always_ff @(posedge fb_clk_i) begin
    if (fb_rst_i) begin
      for (int i = 0; i < S; i++) begin
        sync_q[i] <= FLAG_RST_VEC;
      end
      prev_q <= FLAG_RST_VEC;
    end else begin
      sync_q[0] <= fb_flag_async_i;
      for (int i = 1; i < S; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= flag_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Event detection
  // The mode is used directly with no register, so a mode change takes effect
  // in the same cycle. Switching a high channel to level mode therefore
  // produces an event at once.
  // ---------------------------------------------------------------------------
  logic [N-1:0] flag_event;

  always_comb begin
    flag_event = '0;
    for (int k = 0; k < N; k++) begin
      case (fb_mode_i[2*k +: 2])
        MODE_LEVEL:   flag_event[k] = flag_sync[k];
        MODE_RISING:  flag_event[k] = flag_sync[k] & ~prev_q[k];
        MODE_FALLING: flag_event[k] = ~flag_sync[k] & prev_q[k];
        default:      flag_event[k] = flag_sync[k] ^ prev_q[k];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Event popcount and saturating counter next-state
  // ---------------------------------------------------------------------------
  logic [POP_W-1:0] event_pop;
  logic [SUM_W-1:0] cnt_base;
  logic [SUM_W-1:0] cnt_sum;
  logic [W-1:0]     cnt_next;
  logic [W-1:0]     cnt_q;

  always_comb begin
    event_pop = '0;
    for (int k = 0; k < N; k++) begin
      event_pop = event_pop + POP_W'(flag_event[k]);
    end
  end

  // A counter clear reloads the counter with this cycle's events. Events that
  // occur in the same cycle as the clear are therefore still counted.
  always_comb begin
    cnt_base = fb_cnt_clr_i ? '0 : SUM_W'(cnt_q);
    cnt_sum  = cnt_base + SUM_W'(event_pop);
    cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX[W-1:0] : cnt_sum[W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Sticky status / overflow, interrupt, counter
  // ---------------------------------------------------------------------------
  logic [N-1:0] status_q;
  logic [N-1:0] overflow_q;
  logic         irq_q;

  always_ff @(posedge fb_clk_i) begin
    if (fb_rst_i) begin
      status_q   <= '0;
      overflow_q <= '0;
      irq_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // If an event and a clear arrive together, the event wins for status.
      // In that case the clear still holds overflow low.
      status_q   <= (status_q & ~fb_clear_i) | flag_event;
      overflow_q <= (overflow_q & ~fb_clear_i)
                  | (flag_event & status_q & ~fb_clear_i);
      irq_q      <= |(status_q & fb_mask_i);
      cnt_q      <= cnt_next;
    end
  end

  assign fb_flag_sync_o = flag_sync;
  assign fb_status_o    = status_q;
  assign fb_overflow_o  = overflow_q;
  assign fb_irq_o       = irq_q;
  assign fb_event_cnt_o = cnt_q;

endmodule

// File: tb/tb_spi_ip_flag_bank.sv
// -----------------------------------------------------------------------------
// tb_spi_ip_flag_bank
//
// Directed bench for spi_ip_flag_bank. It uses two instances:
//   u_dut    : default parameters (N=4, S=2, W=4, flag reset 0)
//   u_dut_r1 : same, but with PARAM_FLAG_RESET=1
// Inputs are driven, and outputs sampled, 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_spi_ip_flag_bank;

  localparam int N = 4;
  localparam int W = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic fb_clk_i;
  logic fb_rst_i;
  logic r1_rst;

  initial begin
    fb_clk_i = 1'b0;
    forever #5 fb_clk_i = ~fb_clk_i;
  end

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic [N-1:0]   fb_flag_async_i;
  logic [2*N-1:0] fb_mode_i;
  logic [N-1:0]   fb_mask_i;
  logic [N-1:0]   fb_clear_i;
  logic           fb_cnt_clr_i;
  logic [N-1:0]   fb_flag_sync_o;
  logic [N-1:0]   fb_status_o;
  logic [N-1:0]   fb_overflow_o;
  logic           fb_irq_o;
  logic [W-1:0]   fb_event_cnt_o;

  logic [N-1:0]   r1_async;
  logic [2*N-1:0] r1_mode;
  logic [N-1:0]   r1_mask;
  logic [N-1:0]   r1_clear;
  logic           r1_cnt_clr;
  logic [N-1:0]   r1_sync;
  logic [N-1:0]   r1_status;
  logic [N-1:0]   r1_overflow;
  logic           r1_irq;
  logic [W-1:0]   r1_cnt;

  spi_ip_flag_bank #(
    .PARAM_CHANNELS   (N),
    .PARAM_SYNC_STAGES(2),
    .PARAM_FLAG_RESET (0),
    .PARAM_CNT_WIDTH  (W)
  ) u_dut (
    .fb_clk_i       (fb_clk_i),
    .fb_rst_i       (fb_rst_i),
    .fb_flag_async_i(fb_flag_async_i),
    .fb_mode_i      (fb_mode_i),
    .fb_mask_i      (fb_mask_i),
    .fb_clear_i     (fb_clear_i),
    .fb_cnt_clr_i   (fb_cnt_clr_i),
    .fb_flag_sync_o (fb_flag_sync_o),
    .fb_status_o    (fb_status_o),
    .fb_overflow_o  (fb_overflow_o),
    .fb_irq_o       (fb_irq_o),
    .fb_event_cnt_o (fb_event_cnt_o)
  );

  spi_ip_flag_bank #(
    .PARAM_CHANNELS   (N),
    .PARAM_SYNC_STAGES(2),
    .PARAM_FLAG_RESET (1),
    .PARAM_CNT_WIDTH  (W)
  ) u_dut_r1 (
    .fb_clk_i       (fb_clk_i),
    .fb_rst_i       (r1_rst),
    .fb_flag_async_i(r1_async),
    .fb_mode_i      (r1_mode),
    .fb_mask_i      (r1_mask),
    .fb_clear_i     (r1_clear),
    .fb_cnt_clr_i   (r1_cnt_clr),
    .fb_flag_sync_o (r1_sync),
    .fb_status_o    (r1_status),
    .fb_overflow_o  (r1_overflow),
    .fb_irq_o       (r1_irq),
    .fb_event_cnt_o (r1_cnt)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge fb_clk_i);
      #1;
    end
  endtask

  // Clear all status/overflow and the counter on the main instance.
  task automatic clr_all();
    fb_clear_i   = '1;
    fb_cnt_clr_i = 1'b1;
    tick();
    fb_clear_i   = '0;
    fb_cnt_clr_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    fb_rst_i        = 1'b1;
    fb_flag_async_i = '0;
    fb_mode_i       = 8'b01_01_01_01;
    fb_mask_i       = '0;
    fb_clear_i      = '0;
    fb_cnt_clr_i    = 1'b0;

    r1_rst     = 1'b1;
    r1_async   = 4'b1111;
    r1_mode    = 8'b10_10_10_10;
    r1_mask    = 4'b1111;
    r1_clear   = '0;
    r1_cnt_clr = 1'b0;

    // Reset state
    tick(3);
    fb_rst_i = 1'b0;
    r1_rst   = 1'b0;
    check_eq("rst_status",   32'(fb_status_o),    32'h0);
    check_eq("rst_overflow", 32'(fb_overflow_o),  32'h0);
    check_eq("rst_irq",      32'(fb_irq_o),       32'h0);
    check_eq("rst_cnt",      32'(fb_event_cnt_o), 32'h0);
    check_eq("rst_sync",     32'(fb_flag_sync_o), 32'h0);
    check_eq("r1_rst_sync",  32'(r1_sync),        32'hF);

    // With flag reset 1 and inputs held high through release, the falling
    // mode must not see an edge.
    tick(4);
    check_eq("r1_norel_status", 32'(r1_status), 32'h0);
    check_eq("r1_norel_cnt",    32'(r1_cnt),    32'h0);
    check_eq("r1_norel_irq",    32'(r1_irq),    32'h0);
    check_eq("post_rel_cnt",    32'(fb_event_cnt_o), 32'h0);

    // ch0 rising, mask 0001: sync at edge 2, status at edge 3, irq at edge 4
    fb_mask_i          = 4'b0001;
    fb_flag_async_i[0] = 1'b1;
    tick();
    check_eq("s1_sync_e1",   32'(fb_flag_sync_o), 32'h0);
    tick();
    check_eq("s1_sync_e2",   32'(fb_flag_sync_o), 32'h1);
    check_eq("s1_status_e2", 32'(fb_status_o),    32'h0);
    tick();
    check_eq("s1_status_e3", 32'(fb_status_o),    32'h1);
    check_eq("s1_irq_e3",    32'(fb_irq_o),       32'h0);
    check_eq("s1_cnt_e3",    32'(fb_event_cnt_o), 32'h1);
    tick();
    check_eq("s1_irq_e4",    32'(fb_irq_o),       32'h1);
    check_eq("s1_cnt_e4",    32'(fb_event_cnt_o), 32'h1);
    // A falling input in rising mode makes no event. The clear drops status.
    fb_flag_async_i[0] = 1'b0;
    fb_clear_i         = 4'b0001;
    tick();
    fb_clear_i         = '0;
    tick(4);
    check_eq("s1_clr_status", 32'(fb_status_o),    32'h0);
    check_eq("s1_clr_irq",    32'(fb_irq_o),       32'h0);
    check_eq("s1_fall_cnt",   32'(fb_event_cnt_o), 32'h1);
    fb_cnt_clr_i = 1'b1;
    tick();
    fb_cnt_clr_i = 1'b0;
    check_eq("cnt_clr_idle", 32'(fb_event_cnt_o), 32'h0);

    // ch1 both edges: a pulse gives two events, and the second one overflows
    fb_mask_i          = 4'b0000;
    fb_mode_i          = 8'b01_01_11_01;
    fb_flag_async_i[1] = 1'b1;
    tick(5);
    fb_flag_async_i[1] = 1'b0;
    tick(5);
    check_eq("s2_status",   32'(fb_status_o),    32'h2);
    check_eq("s2_overflow", 32'(fb_overflow_o),  32'h2);
    check_eq("s2_cnt",      32'(fb_event_cnt_o), 32'h2);
    check_eq("s2_irq_mask", 32'(fb_irq_o),       32'h0);
    fb_clear_i = 4'b0010;
    tick();
    fb_clear_i = '0;
    check_eq("s2_clr_overflow", 32'(fb_overflow_o), 32'h0);
    clr_all();

    // ch2 falling: a rise makes no event, a fall sets status, and a second
    // fall with a same-cycle clear keeps status and blocks overflow.
    fb_mode_i          = 8'b01_10_11_01;
    fb_flag_async_i[2] = 1'b1;
    tick(4);
    check_eq("s3_rise_status", 32'(fb_status_o), 32'h0);
    fb_flag_async_i[2] = 1'b0;
    tick(3);
    check_eq("s3_fall_status", 32'(fb_status_o),    32'h4);
    check_eq("s3_fall_cnt",    32'(fb_event_cnt_o), 32'h1);
    fb_flag_async_i[2] = 1'b1;
    tick(4);
    fb_flag_async_i[2] = 1'b0;
    tick(2);
    fb_clear_i = 4'b0100;
    tick();
    fb_clear_i = '0;
    check_eq("s3_evclr_status",   32'(fb_status_o),    32'h4);
    check_eq("s3_evclr_overflow", 32'(fb_overflow_o),  32'h0);
    check_eq("s3_evclr_cnt",      32'(fb_event_cnt_o), 32'h2);
    clr_all();

    // ch3 level mode held high: the count saturates at 15, and a counter
    // clear with one event in the same cycle gives 1.
    fb_mode_i          = 8'b00_10_11_01;
    fb_flag_async_i[3] = 1'b1;
    tick(2);
    check_eq("s4_sync", 32'(fb_flag_sync_o), 32'h8);
    tick();
    check_eq("s4_status_1",   32'(fb_status_o),    32'h8);
    check_eq("s4_overflow_1", 32'(fb_overflow_o),  32'h0);
    check_eq("s4_cnt_1",      32'(fb_event_cnt_o), 32'h1);
    tick();
    check_eq("s4_overflow_2", 32'(fb_overflow_o),  32'h8);
    check_eq("s4_cnt_2",      32'(fb_event_cnt_o), 32'h2);
    tick(18);
    check_eq("s4_cnt_sat", 32'(fb_event_cnt_o), 32'hF);
    fb_cnt_clr_i = 1'b1;
    tick();
    fb_cnt_clr_i = 1'b0;
    check_eq("s4_cnt_clr_ev", 32'(fb_event_cnt_o), 32'h1);
    tick();
    check_eq("s4_cnt_after", 32'(fb_event_cnt_o), 32'h2);
    fb_flag_async_i[3] = 1'b0;
    tick(3);
    clr_all();
    tick();
    check_eq("s4_idle_status", 32'(fb_status_o),    32'h0);
    check_eq("s4_idle_cnt",    32'(fb_event_cnt_o), 32'h0);

    // Events on every channel with all channels masked: no irq. Enabling the
    // ch2 mask raises irq one edge later.
    fb_mode_i       = 8'b01_01_01_01;
    fb_flag_async_i = 4'b1111;
    tick(4);
    check_eq("s6_status",   32'(fb_status_o),    32'hF);
    check_eq("s6_irq_off",  32'(fb_irq_o),       32'h0);
    check_eq("s6_overflow", 32'(fb_overflow_o),  32'h0);
    check_eq("s6_cnt",      32'(fb_event_cnt_o), 32'h4);
    fb_mask_i = 4'b0100;
    check_eq("s6_irq_pre", 32'(fb_irq_o), 32'h0);
    tick();
    check_eq("s6_irq_on", 32'(fb_irq_o), 32'h1);
    // Switching ch0 to level mode while it is high gives an event at once.
    fb_mode_i = 8'b01_01_01_00;
    tick();
    check_eq("s6_lvl_overflow", 32'(fb_overflow_o),  32'h1);
    check_eq("s6_lvl_cnt",      32'(fb_event_cnt_o), 32'h5);

    // Reset during activity overrides clear and cnt_clr, and zeroes all outputs
    fb_rst_i     = 1'b1;
    fb_clear_i   = 4'b0000;
    fb_cnt_clr_i = 1'b1;
    tick();
    check_eq("mid_rst_status",   32'(fb_status_o),    32'h0);
    check_eq("mid_rst_overflow", 32'(fb_overflow_o),  32'h0);
    check_eq("mid_rst_irq",      32'(fb_irq_o),       32'h0);
    check_eq("mid_rst_cnt",      32'(fb_event_cnt_o), 32'h0);
    check_eq("mid_rst_sync",     32'(fb_flag_sync_o), 32'h0);
    fb_cnt_clr_i    = 1'b0;
    fb_flag_async_i = '0;

    // Flag reset 1 instance: a fall works, then reset lands mid-pulse
    r1_async = 4'b1110;
    tick(3);
    check_eq("r1_fall_status", 32'(r1_status), 32'h1);
    check_eq("r1_fall_cnt",    32'(r1_cnt),    32'h1);
    tick();
    check_eq("r1_fall_irq", 32'(r1_irq), 32'h1);
    r1_async = 4'b1111;
    tick();
    r1_async   = 4'b1110;
    r1_rst     = 1'b1;
    r1_cnt_clr = 1'b1;
    r1_clear   = 4'b0000;
    tick();
    check_eq("r1_mid_status",   32'(r1_status),   32'h0);
    check_eq("r1_mid_overflow", 32'(r1_overflow), 32'h0);
    check_eq("r1_mid_irq",      32'(r1_irq),      32'h0);
    check_eq("r1_mid_cnt",      32'(r1_cnt),      32'h0);
    check_eq("r1_mid_sync",     32'(r1_sync),     32'hF);
    r1_async   = 4'b1111;
    r1_cnt_clr = 1'b0;
    tick();
    r1_rst = 1'b0;
    tick(4);
    check_eq("r1_rel_status", 32'(r1_status), 32'h0);
    check_eq("r1_rel_cnt",    32'(r1_cnt),    32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
